piso_shift_tx: RTL and testbench

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/shift_pkg.sv | 11 +
 rtl/word_hold_buf.sv | 39 +++
 rtl/piso_shift_tx.sv | 107 ++++++++++
 tb/tb_piso_shift_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial transmit path: FSM encoding and default word width.
package shift_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/word_hold_buf.sv
// One-word holding buffer that queues the next word while the shifter is busy.
module word_hold_buf
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (wr) begin
        data_q <= wdata;
      end
      // A simultaneous write and read keeps the buffer occupied with the new word.
      if (wr) begin
        full_q <= 1'b1;
      end else if (rd) begin
        full_q <= 1'b0;
      end
    end
  end

  assign rdata = data_q;
  assign full  = full_q;

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: MSB-first bit stream with shift enable and last-bit flag.
module piso_shift_tx
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             stall,
  output logic             so,
  output logic             se,
  output logic             so_last
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             pend_full;
  logic             pend_wr;
  logic             pend_rd;
  logic [WIDTH-1:0] pend_data;
  logic             accept;

  assign din_ready = !rst && !pend_full;
  assign accept    = din_valid && din_ready;

  word_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .wr    (pend_wr),
    .rd    (pend_rd),
    .wdata (din),
    .rdata (pend_data),
    .full  (pend_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    se      = 1'b0;
    so      = 1'b0;
    so_last = 1'b0;
    pend_wr = 1'b0;
    pend_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        se      = !stall;
        so      = shreg_q[WIDTH-1];
        so_last = se && (cnt_q == LAST_CNT);
        // On the last bit the next word goes straight into the shifter so se stays contiguous.
        if (so_last) begin
          cnt_d = '0;
          if (pend_full) begin
            shreg_d = pend_data;
            pend_rd = 1'b1;
          end else if (accept) begin
            shreg_d = din;
          end else begin
            shreg_d = '0;
            state_d = IDLE;
          end
        end else if (se) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
        end
        pend_wr = accept && !so_last;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are quiet for the whole reset cycle, even if the registers still hold a frame.
    if (rst) begin
      se      = 1'b0;
      so      = 1'b0;
      so_last = 1'b0;
      pend_wr = 1'b0;
      pend_rd = 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx (WIDTH=4): per-cycle vector table plus streaming/loopback sequences.
module tb_piso_shift_tx;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       stall;
  logic       so;
  logic       se;
  logic       so_last;

  int n_cmp = 0;
  int n_err = 0;

  piso_shift_tx #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .stall     (stall),
    .so        (so),
    .se        (se),
    .so_last   (so_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream serial-in register: bit enters at bit 0, first bit ends at bit 3.
  logic [3:0] rx_q;
  always_ff @(posedge clk) begin
    if (rst) rx_q <= '0;
    else if (se) rx_q <= {rx_q[2:0], so};
  end

  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] d;
    logic       s;
    logic       e_rdy;
    logic       e_se;
    logic       e_so;
    logic       e_last;
  } vec_t;

  vec_t vt[$];

  logic [3:0] sw[4];
  int         sn;
  int         acc_c[4];
  int         last_c[4];

  task automatic add(input logic r, input logic v, input logic [3:0] d, input logic s,
                     input logic er, input logic ese, input logic eso, input logic el);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.s = s;
    x.e_rdy = er; x.e_se = ese; x.e_so = eso; x.e_last = el;
    vt.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0d want %0d", name, idx, act, exp);
    end
  endtask

  task automatic run_stream(input string tag);
    int   ia;
    int   io;
    int   cyc;
    logic chk;
    ia = 0; io = 0; cyc = 0; chk = 1'b0;
    while (io < sn && cyc < 60) begin
      @(posedge clk); #1;
      if (chk) begin
        check({tag, "_rx"}, io - 1, rx_q, sw[io-1]);
        chk = 1'b0;
      end
      stall     = 1'b0;
      din_valid = (ia < sn);
      din       = (ia < sn) ? sw[ia] : 4'b0000;
      @(negedge clk);
      if (din_valid && din_ready) begin
        acc_c[ia] = cyc;
        ia++;
      end
      if (so_last) begin
        last_c[io] = cyc;
        io++;
        chk = 1'b1;
      end
      cyc++;
    end
    if (chk) begin
      @(posedge clk); #1;
      check({tag, "_rx"}, io - 1, rx_q, sw[io-1]);
    end
    if (io < sn) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d words want %0d", tag, io, sn);
    end
    din_valid = 1'b0;
    din       = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; stall = 1'b0;

    // reset and first idle cycle
    add(1,0,4'b0000,0, 0,0,0,0);
    add(1,0,4'b0000,0, 0,0,0,0);
    add(0,0,4'b0000,0, 1,0,0,0);
    // single word 1011
    add(0,1,4'b1011,0, 1,0,0,0);
    add(0,0,4'b0000,0, 1,1,1,0);
    add(0,0,4'b0000,0, 1,1,0,0);
    add(0,0,4'b0000,0, 1,1,1,0);
    add(0,0,4'b0000,0, 1,1,1,1);
    add(0,0,4'b0000,0, 1,0,0,0);
    // back-to-back 1011, 0110
    add(0,1,4'b1011,0, 1,0,0,0);
    add(0,1,4'b0110,0, 1,1,1,0);
    add(0,0,4'b0000,0, 0,1,0,0);
    add(0,0,4'b0000,0, 0,1,1,0);
    add(0,0,4'b0000,0, 0,1,1,1);
    add(0,0,4'b0000,0, 1,1,0,0);
    add(0,0,4'b0000,0, 1,1,1,0);
    add(0,0,4'b0000,0, 1,1,1,0);
    add(0,0,4'b0000,0, 1,1,0,1);
    add(0,0,4'b0000,0, 1,0,0,0);
    // stall over the second bit of 1011
    add(0,1,4'b1011,0, 1,0,0,0);
    add(0,0,4'b0000,0, 1,1,1,0);
    add(0,0,4'b0000,1, 1,0,0,0);
    add(0,0,4'b0000,1, 1,0,0,0);
    add(0,0,4'b0000,1, 1,0,0,0);
    add(0,0,4'b0000,0, 1,1,0,0);
    add(0,0,4'b0000,0, 1,1,1,0);
    add(0,0,4'b0000,0, 1,1,1,1);
    add(0,0,4'b0000,0, 1,0,0,0);
    // word accepted in IDLE under stall
    add(0,1,4'b1001,1, 1,0,0,0);
    add(0,0,4'b0000,1, 1,0,1,0);
    add(0,0,4'b0000,0, 1,1,1,0);
    add(0,0,4'b0000,0, 1,1,0,0);
    add(0,0,4'b0000,0, 1,1,0,0);
    add(0,0,4'b0000,0, 1,1,1,1);
    add(0,0,4'b0000,0, 1,0,0,0);
    // reset mid-frame with pending full
    add(0,1,4'b1011,0, 1,0,0,0);
    add(0,1,4'b0110,0, 1,1,1,0);
    add(0,0,4'b0000,0, 0,1,0,0);
    add(1,0,4'b0000,0, 0,0,0,0);
    add(1,0,4'b0000,0, 0,0,0,0);
    add(0,0,4'b0000,0, 1,0,0,0);
    add(0,0,4'b0000,0, 1,0,0,0);
    add(0,0,4'b0000,0, 1,0,0,0);

    foreach (vt[i]) begin
      @(posedge clk); #1;
      rst       = vt[i].r;
      din_valid = vt[i].v;
      din       = vt[i].d;
      stall     = vt[i].s;
      @(negedge clk);
      check("din_ready", i, {3'b000, din_ready}, {3'b000, vt[i].e_rdy});
      check("se",        i, {3'b000, se},        {3'b000, vt[i].e_se});
      check("so",        i, {3'b000, so},        {3'b000, vt[i].e_so});
      check("so_last",   i, {3'b000, so_last},   {3'b000, vt[i].e_last});
    end

    // backpressure: third word waits until the first word's last bit has gone
    sw[0] = 4'b1100; sw[1] = 4'b0101; sw[2] = 4'b1110; sw[3] = 4'b0000;
    sn = 3;
    run_stream("bp");
    check_int("bp_acc", 0, acc_c[0], 0);
    check_int("bp_acc", 1, acc_c[1], 1);
    check_int("bp_acc", 2, acc_c[2], 5);
    check_int("bp_last", 0, last_c[0], 4);
    check_int("bp_last", 1, last_c[1], 8);
    check_int("bp_last", 2, last_c[2], 12);

    // loopback into the serial-in register
    sw[0] = 4'b1011; sw[1] = 4'b0110; sw[2] = 4'b1111; sw[3] = 4'b0001;
    sn = 4;
    run_stream("lb");
    check_int("lb_last", 0, last_c[0], 4);
    check_int("lb_last", 3, last_c[3], 16);

    @(posedge clk); #1;
    @(negedge clk);
    check("end_se", 0, {3'b000, se}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
